// File: rtl/fifo_pkg.sv
// Shared types for the flop-based FIFO family: accepted-operation encoding
// and its decode helper.
package fifo_pkg;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_BOTH = 2'd3
   } fifo_op_e;

   function automatic fifo_op_e op_decode(input logic push_ok, input logic pop_ok);
      fifo_op_e op;
      case ({push_ok, pop_ok})
         2'b10:   op = OP_PUSH;
         2'b01:   op = OP_POP;
         2'b11:   op = OP_BOTH;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/fifo_flops_param_if.sv
// Producer/consumer bundle of the parametrised flop FIFO.
// FIFO_ERR_EN adds the overflow/underflow pulses.
interface fifo_flops_param_if #(
   parameter int DEPTH = 16,
   parameter int BITS  = 8
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             push;
   logic             pop;
   logic [BITS-1:0]  Din;
   logic [BITS-1:0]  Dout;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
`ifdef FIFO_ERR_EN
   logic             overflow;
   logic             underflow;
`endif

   modport master (
      output push, pop, Din,
      input  Dout, count, full, empty, almost_full, almost_empty
`ifdef FIFO_ERR_EN
      , input overflow, underflow
`endif
   );

   modport slave (
      input  push, pop, Din,
      output Dout, count, full, empty, almost_full, almost_empty
`ifdef FIFO_ERR_EN
      , output overflow, underflow
`endif
   );

endinterface

// File: rtl/fifo_flops_mem.sv
// DEPTH x BITS flop storage with one write port and a registered read port.
// Storage is never reset; only the read register is.
module fifo_flops_mem #(
   parameter  int DEPTH = 16,
   parameter  int BITS  = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  logic [BITS-1:0]  wdata_i,
   input  logic             re_i,
   input  logic [PTR_W-1:0] raddr_i,
   output logic [BITS-1:0]  rdata_o
);

   logic [BITS-1:0] mem_q [DEPTH];
   logic [BITS-1:0] rdata_q;

   // Storage write.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read; reads the pre-write value when addresses collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_flops_param.sv
// Parametrised flop-based synchronous FIFO with occupancy and threshold flags.
// Define FIFO_ERR_EN to add registered overflow/underflow pulses.
module fifo_flops_param
   import fifo_pkg::*;
#(
   parameter int depth    = 16,
   parameter int bits     = 8,
   parameter int AF_LEVEL = depth - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                clk,
   input  logic                rst,
   fifo_flops_param_if.slave   bus
);

   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = $clog2(depth + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, empty_q, almost_full_q, almost_empty_q;
   logic             push_ok_s, pop_ok_s;
   fifo_op_e         op_s;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(depth - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Accept rules and next-state of pointers and occupancy.
   always_comb begin
      push_ok_s = bus.push & (~full_q | bus.pop);
      pop_ok_s  = bus.pop & ~empty_q;
      op_s      = op_decode(push_ok_s, pop_ok_s);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      case (op_s)
         OP_PUSH: begin
            wr_ptr_d = ptr_next(wr_ptr_q);
            count_d  = count_q + CNT_W'(1);
         end
         OP_POP: begin
            rd_ptr_d = ptr_next(rd_ptr_q);
            count_d  = count_q - CNT_W'(1);
         end
         OP_BOTH: begin
            wr_ptr_d = ptr_next(wr_ptr_q);
            rd_ptr_d = ptr_next(rd_ptr_q);
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   // State registers; flags are decoded from the next count so they track count_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         full_q         <= (count_d == CNT_W'(depth));
         empty_q        <= (count_d == CNT_W'(0));
         almost_full_q  <= (count_d >= CNT_W'(AF_LEVEL));
         almost_empty_q <= (count_d <= CNT_W'(AE_LEVEL));
      end
   end

   fifo_flops_mem #(
      .DEPTH (depth),
      .BITS  (bits)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (push_ok_s & ~rst),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.Din),
      .re_i    (pop_ok_s),
      .raddr_i (rd_ptr_q),
      .rdata_o (bus.Dout)
   );

   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = almost_full_q;
   assign bus.almost_empty = almost_empty_q;

`ifdef FIFO_ERR_EN
   logic overflow_q, underflow_q;

   // One-cycle pulses for rejected requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= bus.push & ~push_ok_s;
         underflow_q <= bus.pop & ~pop_ok_s;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_flops_param.sv
// Self-checking bench: queue-based reference models for a depth-16 and a depth-5
// FIFO, directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_flops_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst16, rst5;
   int   tests = 0;
   int   fails = 0;

   fifo_flops_param_if #(.DEPTH(16), .BITS(8)) bus16 ();
   fifo_flops_param_if #(.DEPTH(5),  .BITS(8)) bus5 ();

   fifo_flops_param #(.depth(16), .bits(8), .AF_LEVEL(14), .AE_LEVEL(2)) dut16 (
      .clk (clk), .rst (rst16), .bus (bus16)
   );
   fifo_flops_param #(.depth(5), .bits(8), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
      .clk (clk), .rst (rst5), .bus (bus5)
   );

   // Reference state
   logic [7:0] q16[$];
   logic [7:0] q5[$];
   logic [7:0] md16, md5;
   logic       ov16, un16, ov5, un5;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mdl16();
      bit pok, puk;
      if (rst16) begin
         q16.delete(); md16 = 8'h00; ov16 = 1'b0; un16 = 1'b0;
      end else begin
         pok = bus16.push && (q16.size() < 16 || bus16.pop);
         puk = bus16.pop && (q16.size() != 0);
         if (puk) md16 = q16.pop_front();
         if (pok) q16.push_back(bus16.Din);
         ov16 = bus16.push && !pok;
         un16 = bus16.pop && !puk;
      end
   endtask

   task automatic mdl5();
      bit pok, puk;
      if (rst5) begin
         q5.delete(); md5 = 8'h00; ov5 = 1'b0; un5 = 1'b0;
      end else begin
         pok = bus5.push && (q5.size() < 5 || bus5.pop);
         puk = bus5.pop && (q5.size() != 0);
         if (puk) md5 = q5.pop_front();
         if (pok) q5.push_back(bus5.Din);
         ov5 = bus5.push && !pok;
         un5 = bus5.pop && !puk;
      end
   endtask

   // One clock: advance models at the edge, compare every output 1 ns later.
   task automatic step();
      @(posedge clk);
      mdl16();
      mdl5();
      #1;
      chk("d16.count", bus16.count,        q16.size());
      chk("d16.full",  bus16.full,         q16.size() == 16);
      chk("d16.empty", bus16.empty,        q16.size() == 0);
      chk("d16.af",    bus16.almost_full,  q16.size() >= 14);
      chk("d16.ae",    bus16.almost_empty, q16.size() <= 2);
      chk("d16.dout",  bus16.Dout,         md16);
      chk("d5.count",  bus5.count,         q5.size());
      chk("d5.full",   bus5.full,          q5.size() == 5);
      chk("d5.empty",  bus5.empty,         q5.size() == 0);
      chk("d5.af",     bus5.almost_full,   q5.size() >= 4);
      chk("d5.ae",     bus5.almost_empty,  q5.size() <= 1);
      chk("d5.dout",   bus5.Dout,          md5);
`ifdef FIFO_ERR_EN
      chk("d16.ovf", bus16.overflow,  ov16);
      chk("d16.unf", bus16.underflow, un16);
      chk("d5.ovf",  bus5.overflow,   ov5);
      chk("d5.unf",  bus5.underflow,  un5);
`endif
   endtask

   task automatic idle();
      bus16.push = 1'b0; bus16.pop = 1'b0; bus16.Din = 8'h00;
      bus5.push  = 1'b0; bus5.pop  = 1'b0; bus5.Din  = 8'h00;
   endtask

   task automatic drive16(input logic ps, input logic pp, input logic [7:0] d);
      bus16.push = ps; bus16.pop = pp; bus16.Din = d;
      step();
   endtask

   initial begin
      idle();
      rst16 = 1'b1; rst5 = 1'b1;
      // 1: reset
      step(); step();
      chk("rst.count", bus16.count, 32'd0);
      chk("rst.empty", bus16.empty, 32'd1);
      chk("rst.ae",    bus16.almost_empty, 32'd1);
      chk("rst.full",  bus16.full, 32'd0);
      chk("rst.dout",  bus16.Dout, 32'h00);
      rst16 = 1'b0; rst5 = 1'b0;

      // 2: fill to full, then a dropped push
      for (int i = 0; i < 16; i++) begin
         drive16(1'b1, 1'b0, 8'(i));
         chk("fill.af",   bus16.almost_full, (i + 1) >= 14);
         chk("fill.full", bus16.full, i == 15);
      end
      drive16(1'b1, 1'b0, 8'hAA);
      chk("ovf.count", bus16.count, 32'd16);
`ifdef FIFO_ERR_EN
      chk("ovf.pulse", bus16.overflow, 32'd1);
      drive16(1'b0, 1'b0, 8'h00);
      chk("ovf.clear", bus16.overflow, 32'd0);
`endif

      // 3: drain in order, then a rejected pop
      for (int i = 0; i < 16; i++) begin
         drive16(1'b0, 1'b1, 8'h00);
         chk("drain.dout", bus16.Dout, 32'(i));
      end
      chk("drain.empty", bus16.empty, 32'd1);
      drive16(1'b0, 1'b1, 8'h00);
      chk("unf.dout", bus16.Dout, 32'h0F);
`ifdef FIFO_ERR_EN
      chk("unf.pulse", bus16.underflow, 32'd1);
`endif

      // 4: push+pop at full
      for (int i = 0; i < 16; i++) drive16(1'b1, 1'b0, 8'(i));
      drive16(1'b1, 1'b1, 8'h55);
      chk("both_full.dout",  bus16.Dout, 32'h00);
      chk("both_full.count", bus16.count, 32'd16);
      for (int i = 0; i < 16; i++) drive16(1'b0, 1'b1, 8'h00);
      chk("both_full.last", bus16.Dout, 32'h55);

      // 5: push+pop at empty
      drive16(1'b1, 1'b1, 8'h33);
      chk("both_empty.count", bus16.count, 32'd1);
      chk("both_empty.dout",  bus16.Dout, 32'h55);
      drive16(1'b0, 1'b1, 8'h00);
      chk("both_empty.next",  bus16.Dout, 32'h33);
      idle();

      // 6: depth 5, pointer wrap with interleaved pairs at count 3
      for (int i = 1; i <= 3; i++) begin
         bus5.push = 1'b1; bus5.pop = 1'b0; bus5.Din = 8'(i);
         step();
      end
      for (int i = 0; i < 12; i++) begin
         bus5.push = 1'b1; bus5.pop = 1'b1; bus5.Din = 8'(8'h10 + i);
         step();
         chk("wrap.dout", bus5.Dout, (i < 3) ? 32'(i + 1) : 32'(8'h10 + i - 3));
      end
      chk("wrap.count", bus5.count, 32'd3);
      bus5.pop = 1'b0; bus5.Din = 8'hEE;
      rst5 = 1'b1;
      step();
      rst5 = 1'b0;
      chk("midrst.count", bus5.count, 32'd0);
      chk("midrst.empty", bus5.empty, 32'd1);
      idle();

      // Randomized traffic with phased fill bias and rare resets
      for (int c = 0; c < 1200; c++) begin
         int bias;
         bias = ((c / 100) % 2 == 0) ? 75 : 25;
         bus16.push = ($urandom_range(0, 99) < bias);
         bus16.pop  = ($urandom_range(0, 99) < (100 - bias));
         bus16.Din  = 8'($urandom);
         bus5.push  = ($urandom_range(0, 99) < bias);
         bus5.pop   = ($urandom_range(0, 99) < (100 - bias));
         bus5.Din   = 8'($urandom);
         rst16      = ($urandom_range(0, 199) == 0);
         rst5       = ($urandom_range(0, 199) == 0);
         step();
      end
      rst16 = 1'b0; rst5 = 1'b0;
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
